imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Boot-time writer for the core's word-addressed instruction memory. The core's fetch path only reads that memory; this block is the other end.
- Accepts a byte stream over a valid/ready handshake: a 4-byte little-endian word-count header, then that many 32-bit little-endian instruction words.
- Issues one write pulse per assembled word and holds the core in reset until loading completes.

Parameters:
- DEPTH, 1024, instruction memory capacity in 32-bit words; largest legal header count.
- BASE, 32'h0, byte address of the first word written.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  re-arm pulse; honoured only in DONE or ERR.
- in_valid  input  1  byte-stream valid.
- in_data  input  8  byte-stream data.
- in_ready  output  1  byte-stream ready.
- wr_en  output  1  instruction memory write strobe, one cycle per word.
- wr_addr  output  32  byte address of the word being written; always word-aligned.
- wr_data  output  32  assembled instruction word.
- cpu_hold  output  1  high = core held in reset / pc frozen.
- done  output  1  one-cycle pulse when a load completes.
- err  output  1  sticky flag: header count exceeded DEPTH.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = HDR, byte counter = 0, word counter = 0, count register = 0.
  - cpu_hold = 1, wr_en = 0, wr_addr = BASE, wr_data = 0, done = 0, err = 0.
- Reset mid-load abandons the load. No wr_en pulse may occur in the cycle after rst_n releases.
- Byte acceptance:
  - A byte is accepted on a rising edge with in_valid & in_ready.
  - in_ready is decoded from state only: 1 in HDR and DATA, 0 in FLUSH, DONE and ERR.
  - in_data is ignored when in_valid is low. Gaps of any length between bytes are legal.
- HDR state:
  - The byte counter (0..3) places byte k into count[8k+7:8k].
  - On the 4th accepted byte, using the full count value:
    - count == 0 -> DONE; done = 1 for one cycle, cpu_hold = 0; no writes.
    - count > DEPTH -> ERR; err = 1, cpu_hold stays 1.
    - otherwise -> DATA; byte counter and word counter = 0.
- DATA state:
  - Accepted bytes fill a shift register little-endian: byte 0 -> bits [7:0] … byte 3 -> bits [31:24].
  - On the edge accepting byte 3 of word i:
    - wr_en = 1, wr_data = assembled word, wr_addr = BASE + 4*i. The pulse is visible in the following cycle.
    - The word counter increments.
  - wr_en drops after exactly one cycle unless the next word's byte 3 is accepted on that edge. Back-to-back words every 4 cycles are supported.
  - Accepting byte 3 of the last word (i == count-1) moves to FLUSH.
- FLUSH state (1 cycle): on the next edge wr_en = 0, state = DONE, done = 1 for one cycle, cpu_hold = 0.
  - cpu_hold therefore falls exactly one cycle after the final wr_en pulse, so the last write lands before the core fetches.
- DONE state:
  - cpu_hold = 0, in_ready = 0.
  - start -> HDR, cpu_hold = 1, counters = 0, wr_addr = BASE.
- ERR state:
  - err = 1, cpu_hold = 1, in_ready = 0, no writes.
  - start -> HDR, err = 0, counters = 0.
- start is ignored in HDR, DATA and FLUSH. A start in the same cycle as the FLUSH->DONE transition is ignored.
- Counter widths:
  - The word counter is wide enough for DEPTH.
  - wr_addr arithmetic is 32-bit modulo 2^32. No alignment fault is possible because BASE is required to be word-aligned.
- done is only a pulse; cpu_hold is the level indication of load completion.

Test Plan:
- Reset then release:
  - -> cpu_hold=1, in_ready=1, wr_en=0, err=0, done=0.
  - No activity for 10 cycles with in_valid=0.
- Header 02 00 00 00, then 78 56 34 12 EF BE AD DE, back-to-back:
  - -> wr_en pulses with (addr 0x0, data 0x12345678) and (addr 0x4, data 0xDEADBEEF).
  - done pulses 1 cycle after the 2nd pulse; cpu_hold=0 from that cycle.
- Same stream with random in_valid gaps, and in_data=0xFF driven while in_valid=0:
  - -> identical writes.
  - No wr_en before each 4th byte.
  - start pulses during DATA are ignored.
- Header 00 00 00 00:
  - -> done pulse, zero wr_en pulses, cpu_hold=0.
  - Then start -> HDR, cpu_hold=1, in_ready=1.
- Header 01 04 00 00 (count 1025, DEPTH=1024):
  - -> err=1, in_ready=0, cpu_hold=1, no writes.
  - start -> err=0; a subsequent valid 1-word load succeeds at addr 0x0.
- rst_n pulsed low after 5 DATA bytes:
  - -> immediate reset values, no wr_en after release.
  - A fresh full load then writes from BASE.

Source files
------------

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write bus for the boot loader.
//   in_valid / in_data / in_ready : byte stream, one byte per accepted cycle
//   wr_en / wr_addr / wr_data     : one-cycle word write strobe into instruction memory
// slave  = the loader side (consumes bytes, drives writes)
// master = the environment side (supplies bytes, observes writes)
interface imem_loader_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;

  modport slave  (input  in_valid, in_data, output in_ready, wr_en, wr_addr, wr_data);
  modport master (output in_valid, in_data, input  in_ready, wr_en, wr_addr, wr_data);
endinterface

// File: rtl/imem_loader.sv
// Boot-time writer for the word-addressed instruction memory.
// Consumes a 4-byte little-endian word-count header followed by that many
// little-endian 32-bit words, issues one write pulse per word, and holds the
// core in reset until the load completes.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   start      : re-arm pulse, honoured only once a load finished or failed
//   bus        : byte stream in, instruction-memory writes out
//   cpu_hold   : high while the core must stay in reset
//   done       : one-cycle pulse when a load completes
//   err        : high while parked after a header count larger than DEPTH
module imem_loader #(
  parameter int unsigned DEPTH = 1024,
  parameter logic [31:0] BASE  = 32'h0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  imem_loader_if.slave bus,
  output logic         cpu_hold,
  output logic         done,
  output logic         err
);

  localparam int unsigned WCW = $clog2(DEPTH + 1);

  typedef enum logic [2:0] {
    S_HDR,
    S_DATA,
    S_FLUSH,
    S_DONE,
    S_ERR
  } state_t;

  state_t          state, state_d;
  logic [1:0]      byte_cnt;
  logic [WCW-1:0]  word_cnt;
  logic [31:0]     count;
  logic [23:0]     shift;

  logic            accept;
  logic            last_byte;
  logic [31:0]     hdr_full;
  logic [31:0]     word_idx;
  logic            wr_fire;
  logic            done_set;
  logic            rearm;

  // in_ready depends on state only, never on in_valid.
  assign bus.in_ready = (state == S_HDR) || (state == S_DATA);
  assign accept       = bus.in_valid && bus.in_ready;
  assign last_byte    = (byte_cnt == 2'd3);
  // Complete header as it will be once the byte on the bus is captured.
  assign hdr_full     = {bus.in_data, count[23:0]};
  assign word_idx     = 32'(word_cnt);
  assign cpu_hold     = (state != S_DONE);
  assign err          = (state == S_ERR);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_HDR;
    else        state <= state_d;
  end

  // NOTE: every signal written here gets a default first, otherwise paths
  // that skip an assignment would infer latches.
  always_comb begin
    state_d  = state;
    wr_fire  = 1'b0;
    done_set = 1'b0;
    rearm    = 1'b0;
    case (state)
      S_HDR: begin
        if (accept && last_byte) begin
          if (hdr_full == 32'd0) begin
            state_d  = S_DONE;
            done_set = 1'b1;
          end else if (hdr_full > 32'(DEPTH)) begin
            state_d = S_ERR;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept && last_byte) begin
          wr_fire = 1'b1;
          if (word_idx + 32'd1 == count) state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        // Gives the final write one cycle to land before cpu_hold drops.
        state_d  = S_DONE;
        done_set = 1'b1;
      end
      S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_HDR;
          rearm   = 1'b1;
        end
      end
      default: state_d = S_HDR;
    endcase
  end

  // NOTE: the datapath registers, including wr_data and the assembly shift
  // register, are reset as well because their reset values are observable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt    <= 2'd0;
      word_cnt    <= '0;
      count       <= 32'd0;
      shift       <= 24'd0;
      bus.wr_en   <= 1'b0;
      bus.wr_addr <= BASE;
      bus.wr_data <= 32'd0;
      done        <= 1'b0;
    end else begin
      bus.wr_en <= wr_fire;
      done      <= done_set;

      if (accept) begin
        // Wraps 3 -> 0, so each header/word starts at byte 0.
        byte_cnt <= byte_cnt + 2'd1;
        if (state == S_HDR) begin
          count[{byte_cnt, 3'b000} +: 8] <= bus.in_data;
        end else if (!last_byte) begin
          shift[{byte_cnt, 3'b000} +: 8] <= bus.in_data;
        end
      end

      if (state == S_HDR && accept && last_byte) word_cnt <= '0;

      if (wr_fire) begin
        bus.wr_data <= {bus.in_data, shift};
        bus.wr_addr <= BASE + (word_idx << 2);
        word_cnt    <= word_cnt + WCW'(1);
      end

      if (rearm) begin
        byte_cnt    <= 2'd0;
        word_cnt    <= '0;
        count       <= 32'd0;
        bus.wr_addr <= BASE;
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed load scenarios with random
// words and random byte gaps, checked against a stream-level reference model.
module tb_imem_loader;

  localparam int unsigned DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h0;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic cpu_hold, done, err;

  imem_loader_if bus ();

  imem_loader #(.DEPTH(DEPTH), .BASE(BASE)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .bus      (bus),
    .cpu_hold (cpu_hold),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int wr_pulses = 0;

  logic [31:0] words[$];
  logic [7:0]  stream[$];

  always @(negedge clk) if (bus.wr_en === 1'b1) wr_pulses++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference stream: header bytes then word bytes, all little-endian.
  function automatic void build_stream(input logic [31:0] cnt);
    stream.delete();
    for (int k = 0; k < 4; k++) stream.push_back(8'((cnt >> (8 * k)) & 32'hFF));
    foreach (words[i])
      for (int k = 0; k < 4; k++) stream.push_back(8'((words[i] >> (8 * k)) & 32'hFF));
  endfunction

  task automatic check_idle_outputs(input string tag, input logic exp_hold,
                                    input logic exp_ready, input logic exp_err);
    check({tag, "_wr_en"},    bus.wr_en,    32'd0);
    check({tag, "_done"},     done,         32'd0);
    check({tag, "_cpu_hold"}, cpu_hold,     32'(exp_hold));
    check({tag, "_in_ready"}, bus.in_ready, 32'(exp_ready));
    check({tag, "_err"},      err,          32'(exp_err));
  endtask

  // Sends n_send bytes of the stream for header cnt (n_send < 0: whole stream).
  task automatic run_load(input logic [31:0] cnt, input int n_send,
                          input bit gaps, input bit noise_start);
    int  n;
    bit  legal, is_wr, exp_done, exp_err;
    int  wi;
    build_stream(cnt);
    wr_pulses = 0;
    legal = (cnt <= DEPTH);
    n = (n_send < 0) ? stream.size() : n_send;
    for (int j = 0; j < n; j++) begin
      if (gaps) begin
        int rn;
        rn = $urandom_range(0, 3);
        for (int g = 0; g < rn; g++) begin
          @(negedge clk);
          bus.in_valid = 1'b0;
          bus.in_data  = 8'hFF;
          start = (noise_start && j >= 4) ? 1'($urandom_range(0, 1)) : 1'b0;
          @(posedge clk); #1;
          check("gap_wr_en", bus.wr_en, 32'd0);
          check("gap_done",  done,      32'd0);
        end
      end
      @(negedge clk);
      start        = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_data  = stream[j];
      check("byte_in_ready", bus.in_ready, 32'd1);
      @(posedge clk); #1;
      is_wr    = legal && (j >= 7) && (((j - 4) % 4) == 3);
      wi       = (j >= 4) ? (j - 4) / 4 : 0;
      exp_done = (j == 3) && (cnt == 0);
      exp_err  = (j >= 3) && !legal;
      check("byte_wr_en", bus.wr_en, 32'(is_wr));
      if (is_wr) begin
        check("wr_addr", bus.wr_addr, BASE + 32'(4 * wi));
        check("wr_data", bus.wr_data, words[wi]);
      end
      check("byte_done",     done,     32'(exp_done));
      check("byte_err",      err,      32'(exp_err));
      check("byte_cpu_hold", cpu_hold, 32'(!exp_done));
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_data  = 8'hFF;
    if (n_send < 0) begin
      if (cnt == 0 || !legal) begin
        @(posedge clk); #1;
        check_idle_outputs("park", !legal, 1'b0, !legal);
      end else begin
        // A start landing on the FLUSH->DONE edge must be ignored.
        start = noise_start;
        @(posedge clk); #1;
        check("flush_wr_en",    bus.wr_en,    32'd0);
        check("flush_done",     done,         32'd1);
        check("flush_cpu_hold", cpu_hold,     32'd0);
        check("flush_in_ready", bus.in_ready, 32'd0);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk); #1;
        check_idle_outputs("after_done", 1'b0, 1'b0, 1'b0);
      end
      check("wr_pulse_count", 32'(wr_pulses), legal ? cnt : 32'd0);
    end
  endtask

  task automatic restart();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    check("restart_cpu_hold", cpu_hold,     32'd1);
    check("restart_in_ready", bus.in_ready, 32'd1);
    check("restart_err",      err,          32'd0);
    check("restart_done",     done,         32'd0);
    check("restart_wr_addr",  bus.wr_addr,  BASE);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic random_words(input int cnt);
    words.delete();
    for (int i = 0; i < cnt; i++) words.push_back($urandom);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;

    // Reset state, then 10 quiet cycles.
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset", 1'b1, 1'b1, 1'b0);
    check("reset_wr_addr", bus.wr_addr, BASE);
    check("reset_wr_data", bus.wr_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      check_idle_outputs("quiet", 1'b1, 1'b1, 1'b0);
    end

    // Two-word load, back-to-back bytes.
    words = '{32'h1234_5678, 32'hDEAD_BEEF};
    run_load(32'd2, -1, 1'b0, 1'b0);
    restart();

    // Same stream with gaps, junk data while idle, and ignored start pulses.
    run_load(32'd2, -1, 1'b1, 1'b1);
    restart();

    // Zero-length load.
    words.delete();
    run_load(32'd0, -1, 1'b0, 1'b0);
    restart();

    // Oversized header parks in ERR; re-arm then a 1-word load.
    run_load(32'd1025, -1, 1'b0, 1'b0);
    restart();
    random_words(1);
    run_load(32'd1, -1, 1'b1, 1'b0);
    restart();

    // Reset after 5 data bytes abandons the load.
    random_words(3);
    run_load(32'd3, 9, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("midreset", 1'b1, 1'b1, 1'b0);
    check("midreset_wr_addr", bus.wr_addr, BASE);
    check("midreset_wr_data", bus.wr_data, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wr_pulses = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      check("post_reset_wr_en", bus.wr_en, 32'd0);
    end
    check("post_reset_pulses", 32'(wr_pulses), 32'd0);
    run_load(32'd3, -1, 1'b1, 1'b0);
    restart();

    // Largest legal header.
    random_words(DEPTH);
    run_load(32'(DEPTH), -1, 1'b0, 1'b0);
    restart();

    // A few random small loads.
    for (int t = 0; t < 4; t++) begin
      int c;
      c = $urandom_range(1, 8);
      random_words(c);
      run_load(32'(c), -1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      restart();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
